// File: rtl/playbus_seq_if.sv
// Bus bundle between the PlayBus transfer sequencer and its environment.
// The burst_len member exists only when PLAYBUS_BURST_EN is defined.
interface playbus_seq_if #(
  parameter int WIDTH  = 4,
  parameter int AWIDTH = 3,
  parameter int CWIDTH = 8
) ();
  logic              start;
  logic [1:0]        src;
  logic [1:0]        dst;
  logic [AWIDTH-1:0] addr_in;
  logic [WIDTH-1:0]  bus_in;
`ifdef PLAYBUS_BURST_EN
  logic [AWIDTH-1:0] burst_len;
`endif
  logic              sw_en;
  logic              rom_oe;
  logic              ram_oe;
  logic              ram_we;
  logic              led_ltch;
  logic [AWIDTH-1:0] address;
  logic [WIDTH-1:0]  led_out;
  logic              busy;
  logic              done;
  logic              error;
  logic [CWIDTH-1:0] xfer_count;

`ifdef PLAYBUS_BURST_EN
  modport master (output start, src, dst, addr_in, bus_in, burst_len,
                  input  sw_en, rom_oe, ram_oe, ram_we, led_ltch, address,
                         led_out, busy, done, error, xfer_count);
  modport slave  (input  start, src, dst, addr_in, bus_in, burst_len,
                  output sw_en, rom_oe, ram_oe, ram_we, led_ltch, address,
                         led_out, busy, done, error, xfer_count);
`else
  modport master (output start, src, dst, addr_in, bus_in,
                  input  sw_en, rom_oe, ram_oe, ram_we, led_ltch, address,
                         led_out, busy, done, error, xfer_count);
  modport slave  (input  start, src, dst, addr_in, bus_in,
                  output sw_en, rom_oe, ram_oe, ram_we, led_ltch, address,
                         led_out, busy, done, error, xfer_count);
`endif
endinterface

// File: rtl/playbus_seq.sv
// PlayBus transfer sequencer: moves one word source->sink with break-before-make.
// Define PLAYBUS_BURST_EN to enable multi-word bursts with an incrementing address.
module playbus_seq #(
  parameter int WIDTH  = 4,
  parameter int AWIDTH = 3,
  parameter int SETTLE = 1,
  parameter int CWIDTH = 8
) (
  input logic          clk,
  input logic          reset,
  playbus_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RELEASE} state_t;

  state_t            state;
  logic [1:0]        src_q;
  logic [1:0]        dst_q;
  logic [3:0]        settle_cnt;
  logic [2:0]        src_en;
  logic              ram_we_q;
  logic              led_ltch_q;
  logic [AWIDTH-1:0] addr_q;
  logic [WIDTH-1:0]  led_q;
  logic              done_q;
  logic              error_q;
  logic [CWIDTH-1:0] count_q;
  logic              illegal;
`ifdef PLAYBUS_BURST_EN
  logic [AWIDTH-1:0] remain;
`endif

  // Bit 0 = switch buffer, bit 1 = ROM, bit 2 = RAM; "none" drives nothing.
  function automatic logic [2:0] src_oh(input logic [1:0] s);
    case (s)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    illegal = (bus.src == 2'b11) || bus.dst[1] ||
              ((bus.src == 2'b10) && (bus.dst == 2'b01));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      src_q      <= 2'b00;
      dst_q      <= 2'b00;
      settle_cnt <= 4'd0;
      src_en     <= 3'b000;
      ram_we_q   <= 1'b0;
      led_ltch_q <= 1'b0;
      addr_q     <= '0;
      led_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
`ifdef PLAYBUS_BURST_EN
      remain     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (illegal) begin
              error_q <= 1'b1;
            end else begin
              error_q    <= 1'b0;
              addr_q     <= bus.addr_in;
              src_q      <= bus.src;
              dst_q      <= bus.dst;
              settle_cnt <= 4'(SETTLE);
              src_en     <= src_oh(bus.src);
`ifdef PLAYBUS_BURST_EN
              remain     <= bus.burst_len;
`endif
              state      <= DRIVE;
            end
          end
        end
        DRIVE: begin
          src_en <= src_oh(src_q);
          if (settle_cnt == 4'd1) begin
            ram_we_q   <= (dst_q == 2'b01);
            led_ltch_q <= (dst_q == 2'b00);
            state      <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        CAPTURE: begin
          // Strobes and enables all drop together into the turnaround cycle.
          src_en     <= 3'b000;
          ram_we_q   <= 1'b0;
          led_ltch_q <= 1'b0;
          if (dst_q == 2'b00) led_q <= bus.bus_in;
          count_q    <= count_q + CWIDTH'(1);
`ifdef PLAYBUS_BURST_EN
          done_q     <= (remain == '0);
`else
          done_q     <= 1'b1;
`endif
          state      <= RELEASE;
        end
        RELEASE: begin
          done_q <= 1'b0;
`ifdef PLAYBUS_BURST_EN
          if (remain != '0) begin
            remain     <= remain - AWIDTH'(1);
            addr_q     <= addr_q + AWIDTH'(1);
            settle_cnt <= 4'(SETTLE);
            src_en     <= src_oh(src_q);
            state      <= DRIVE;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sw_en      = src_en[0];
  assign bus.rom_oe     = src_en[1];
  assign bus.ram_oe     = src_en[2];
  assign bus.ram_we     = ram_we_q;
  assign bus.led_ltch   = led_ltch_q;
  assign bus.address    = addr_q;
  assign bus.led_out    = led_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.xfer_count = count_q;
endmodule

// File: tb/tb_playbus_seq.sv
// Self-checking bench: two sequencers (SETTLE=1 and SETTLE=3) share stimulus and
// are compared every cycle against a transfer-level reference model.
module tb_playbus_seq;
  localparam int W = 4;
  localparam int A = 3;
  localparam int C = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   src;
  logic [1:0]   dst;
  logic [A-1:0] addr_in;
  logic [W-1:0] bus_in;
  logic [A-1:0] burst_len;

  int errors = 0;
  int checks = 0;

  playbus_seq_if #(.WIDTH(W), .AWIDTH(A), .CWIDTH(C)) if1 ();
  playbus_seq_if #(.WIDTH(W), .AWIDTH(A), .CWIDTH(C)) if3 ();

  assign if1.start = start;   assign if3.start = start;
  assign if1.src = src;       assign if3.src = src;
  assign if1.dst = dst;       assign if3.dst = dst;
  assign if1.addr_in = addr_in; assign if3.addr_in = addr_in;
  assign if1.bus_in = bus_in; assign if3.bus_in = bus_in;
`ifdef PLAYBUS_BURST_EN
  assign if1.burst_len = burst_len;
  assign if3.burst_len = burst_len;
`endif

  playbus_seq #(.WIDTH(W), .AWIDTH(A), .SETTLE(1), .CWIDTH(C)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  playbus_seq #(.WIDTH(W), .AWIDTH(A), .SETTLE(3), .CWIDTH(C)) dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a transfer of n words lasts n*(S+2) cycles after acceptance;
  // k counts those cycles, p is the position inside the current word.
  int           m_settle [2] = '{1, 3};
  bit           m_act [2];
  int           m_k [2];
  int           m_n [2];
  logic [1:0]   m_src [2];
  logic [1:0]   m_dst [2];
  logic [A-1:0] m_addr [2];
  logic [W-1:0] m_led [2];
  logic [C-1:0] m_cnt [2];
  bit           m_err [2];

  function automatic bit is_illegal(logic [1:0] s, logic [1:0] d);
    return (s == 2'b11) || (d == 2'b10) || (d == 2'b11) || (s == 2'b10 && d == 2'b01);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_n[i] = 1; m_src[i] = 0; m_dst[i] = 0;
      m_addr[i] = 0; m_led[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_update(int i);
    int len;
    int p;
    len = m_settle[i] + 2;
    if (m_act[i]) begin
      p = (m_k[i] - 1) % len + 1;
      if (p == m_settle[i] + 1) begin
        if (m_dst[i] == 2'b00) m_led[i] = bus_in;
        m_cnt[i] = m_cnt[i] + 1'b1;
      end
      if (m_k[i] == m_n[i] * len) m_act[i] = 0;
      else begin
        if (p == len) m_addr[i] = m_addr[i] + 1'b1;
        m_k[i]++;
      end
    end else if (start) begin
      if (is_illegal(src, dst)) m_err[i] = 1;
      else begin
        m_err[i] = 0; m_act[i] = 1; m_k[i] = 1;
        m_src[i] = src; m_dst[i] = dst; m_addr[i] = addr_in;
`ifdef PLAYBUS_BURST_EN
        m_n[i] = int'(burst_len) + 1;
`else
        m_n[i] = 1;
`endif
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int i);
    logic sw, rom, ram, we, ll, bsy, dn, er;
    logic [A-1:0] ad;
    logic [W-1:0] lo;
    logic [C-1:0] cn;
    int len, p;
    bit en;
    string t;
    if (i == 0) begin
      sw = if1.sw_en; rom = if1.rom_oe; ram = if1.ram_oe; we = if1.ram_we;
      ll = if1.led_ltch; bsy = if1.busy; dn = if1.done; er = if1.error;
      ad = if1.address; lo = if1.led_out; cn = if1.xfer_count;
    end else begin
      sw = if3.sw_en; rom = if3.rom_oe; ram = if3.ram_oe; we = if3.ram_we;
      ll = if3.led_ltch; bsy = if3.busy; dn = if3.done; er = if3.error;
      ad = if3.address; lo = if3.led_out; cn = if3.xfer_count;
    end
    t   = $sformatf("s%0d", m_settle[i]);
    len = m_settle[i] + 2;
    p   = m_act[i] ? (m_k[i] - 1) % len + 1 : 0;
    en  = m_act[i] && (p <= m_settle[i] + 1);
    chk({t, " onehot"},   32'($countones({sw, rom, ram}) <= 1), 32'(1));
    chk({t, " sw_en"},    32'(sw),  32'(en && m_src[i] == 2'b00));
    chk({t, " rom_oe"},   32'(rom), 32'(en && m_src[i] == 2'b01));
    chk({t, " ram_oe"},   32'(ram), 32'(en && m_src[i] == 2'b10));
    chk({t, " ram_we"},   32'(we),  32'(m_act[i] && p == m_settle[i] + 1 && m_dst[i] == 2'b01));
    chk({t, " led_ltch"}, 32'(ll),  32'(m_act[i] && p == m_settle[i] + 1 && m_dst[i] == 2'b00));
    chk({t, " busy"},     32'(bsy), 32'(m_act[i]));
    chk({t, " done"},     32'(dn),  32'(m_act[i] && m_k[i] == m_n[i] * len));
    chk({t, " error"},    32'(er),  32'(m_err[i]));
    chk({t, " address"},  32'(ad),  32'(m_addr[i]));
    chk({t, " led_out"},  32'(lo),  32'(m_led[i]));
    chk({t, " count"},    32'(cn),  32'(m_cnt[i]));
  endtask

  task automatic applyStimulus();
    model_update(0);
    model_update(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput();
    check_dut(0);
    check_dut(1);
  endtask

  task automatic step(int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus();
      checkOutput();
    end
  endtask

  task automatic pulse_start(logic [1:0] s, logic [1:0] d, logic [A-1:0] a, logic [W-1:0] b);
    src = s; dst = d; addr_in = a; bus_in = b; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src = 0; dst = 0; addr_in = 0; bus_in = 0; burst_len = 0;
    model_reset();
    #1 checkOutput();
    @(negedge clk);
    @(negedge clk);
    checkOutput();
    reset = 1'b0;
    step(2);

    pulse_start(2'b00, 2'b00, 3'd0, 4'hA);
    step(7);
    pulse_start(2'b01, 2'b01, 3'b101, 4'h3);
    step(7);
    pulse_start(2'b10, 2'b01, 3'd2, 4'h5);
    step(3);
    pulse_start(2'b00, 2'b01, 3'd1, 4'h6);
    step(7);

    // Reset lands on the second DRIVE cycle of the SETTLE=3 unit.
    pulse_start(2'b01, 2'b00, 3'd4, 4'h9);
    step(1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("rst rom_oe s3", 32'(if3.rom_oe), 32'(0));
    chk("rst busy s3", 32'(if3.busy), 32'(0));
    chk("rst count s3", 32'(if3.xfer_count), 32'(0));
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    step(6);

    src = 2'b00; dst = 2'b00; addr_in = 3'd3; start = 1'b1;
    for (int c = 0; c < 1100; c++) begin
      bus_in = W'($urandom);
      step(1);
    end
    start = 1'b0;
    step(8);

`ifdef PLAYBUS_BURST_EN
    burst_len = 3'd3;
    pulse_start(2'b01, 2'b01, 3'd6, 4'h2);
    step(22);
    burst_len = 3'd2;
    pulse_start(2'b00, 2'b00, 3'd7, 4'hC);
    step(12);
`endif

    for (int c = 0; c < 600; c++) begin
      start   = ($urandom % 3) == 0;
      src     = 2'($urandom);
      dst     = 2'($urandom);
      addr_in = A'($urandom);
      bus_in  = W'($urandom);
`ifdef PLAYBUS_BURST_EN
      burst_len = A'($urandom_range(0, 2));
`endif
      step(1);
    end
    start = 1'b0;
    step(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
